// File: rtl/faulty_mem_array.sv
// Fault-injectable memory model for MBIST bring-up: main array with spare row and
// spare column, an initialization sweep, and a small table of stuck-at and
// transition faults overlaid on main-array accesses.
module faulty_mem_array #(
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int COL_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_INJ        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ROW_ADDR_WIDTH-1:0]     row_addr,
  input  logic [COL_ADDR_WIDTH-1:0]     col_addr,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          mem_ready,
  input  logic                          inj_valid,
  output logic                          inj_ready,
  input  logic [ROW_ADDR_WIDTH-1:0]     inj_row,
  input  logic [COL_ADDR_WIDTH-1:0]     inj_col,
  input  logic [$clog2(DATA_WIDTH)-1:0] inj_bit,
  input  logic [1:0]                    inj_type,
  output logic [$clog2(NUM_INJ+1)-1:0]  inj_count,
  input  logic                          rep_row_en,
  input  logic [ROW_ADDR_WIDTH-1:0]     rep_row,
  input  logic                          rep_col_en,
  input  logic [COL_ADDR_WIDTH-1:0]     rep_col
);

  // state | meaning
  // INIT  | sweep writes zero to one main address (plus matching spare words) per cycle
  // READY | sweep done; normal read/write with fault overlay and remap

  localparam int ADDR_W = ROW_ADDR_WIDTH + COL_ADDR_WIDTH;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam int CNT_W  = $clog2(NUM_INJ + 1);

  localparam logic [1:0] TYPE_CLR = 2'b00;
  localparam logic [1:0] TYPE_SA0 = 2'b01;
  localparam logic [1:0] TYPE_SA1 = 2'b10;
  localparam logic [1:0] TYPE_TF  = 2'b11;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] sweep_addr;

  logic [DATA_WIDTH-1:0] main_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] spare_row [1 << COL_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] spare_col [1 << ROW_ADDR_WIDTH];

  logic [NUM_INJ-1:0]        ent_valid;
  logic [ROW_ADDR_WIDTH-1:0] ent_row  [NUM_INJ];
  logic [COL_ADDR_WIDTH-1:0] ent_col  [NUM_INJ];
  logic [BIT_W-1:0]          ent_bit  [NUM_INJ];
  logic [1:0]                ent_type [NUM_INJ];

  logic [ADDR_W-1:0]     acc_addr;
  logic                  sel_row, sel_col, sel_main;
  logic [DATA_WIDTH-1:0] raw_word, wr_word;
  logic [DATA_WIDTH-1:0] sa0_mask, sa1_mask, tf_mask;

  logic [NUM_INJ-1:0] match_sel, alloc_sel;
  logic               match_hit, free_hit, inj_accept;

  // FSM state register and sweep counter; the counter only advances during INIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      sweep_addr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        sweep_addr <= sweep_addr + 1'b1;
      end
    end
  end

  // Next state: leave INIT once the last sweep address has been written
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && sweep_addr == '1) begin
      state_d = ST_READY;
    end
  end

  assign mem_ready = (state_q == ST_READY);

  // Access decode: spare row wins over spare column, otherwise the main array
  assign acc_addr = {row_addr, col_addr};
  assign sel_row  = rep_row_en && (row_addr == rep_row);
  assign sel_col  = !sel_row && rep_col_en && (col_addr == rep_col);
  assign sel_main = !sel_row && !sel_col;

  // Raw stored word at the access address, before any fault overlay
  always_comb begin
    raw_word = main_mem[acc_addr];
    if (sel_row) begin
      raw_word = spare_row[col_addr];
    end else if (sel_col) begin
      raw_word = spare_col[row_addr];
    end
  end

  // Collect per-bit fault masks from every valid entry on the accessed cell
  always_comb begin
    sa0_mask = '0;
    sa1_mask = '0;
    tf_mask  = '0;
    for (int i = 0; i < NUM_INJ; i++) begin
      if (ent_valid[i] && ent_row[i] == row_addr && ent_col[i] == col_addr) begin
        case (ent_type[i])
          TYPE_SA0: sa0_mask[ent_bit[i]] = 1'b1;
          TYPE_SA1: sa1_mask[ent_bit[i]] = 1'b1;
          TYPE_TF:  tf_mask[ent_bit[i]]  = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Read path: zero during INIT, stuck-at overlay only on main-array hits
  always_comb begin
    data_out = '0;
    if (state_q == ST_READY) begin
      data_out = sel_main ? ((raw_word & ~sa0_mask) | sa1_mask) : raw_word;
    end
  end

  // A transition-faulted bit that currently holds 0 cannot be written to 1
  assign wr_word = sel_main ? (data_in & ~(tf_mask & ~raw_word)) : data_in;

  // Storage update: zero sweep in INIT, remapped write in READY
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        main_mem[sweep_addr]                          <= '0;
        spare_row[sweep_addr[COL_ADDR_WIDTH-1:0]]     <= '0;
        spare_col[sweep_addr[ADDR_W-1:COL_ADDR_WIDTH]] <= '0;
      end else if (wr_en) begin
        if (sel_row) begin
          spare_row[col_addr] <= wr_word;
        end else if (sel_col) begin
          spare_col[row_addr] <= wr_word;
        end else begin
          main_mem[acc_addr] <= wr_word;
        end
      end
    end
  end

  // Find an existing entry for the requested cell/bit and the lowest free slot
  always_comb begin
    match_sel = '0;
    alloc_sel = '0;
    match_hit = 1'b0;
    free_hit  = 1'b0;
    for (int i = 0; i < NUM_INJ; i++) begin
      if (ent_valid[i] && !match_hit && ent_row[i] == inj_row &&
          ent_col[i] == inj_col && ent_bit[i] == inj_bit) begin
        match_sel[i] = 1'b1;
        match_hit    = 1'b1;
      end
      if (!ent_valid[i] && !free_hit) begin
        alloc_sel[i] = 1'b1;
        free_hit     = 1'b1;
      end
    end
  end

  assign inj_ready  = (inj_type == TYPE_CLR) || free_hit || match_hit;
  assign inj_accept = inj_valid && inj_ready;

  // Occupancy is the number of valid entries, so it saturates with the table
  always_comb begin
    inj_count = '0;
    for (int i = 0; i < NUM_INJ; i++) begin
      inj_count = inj_count + CNT_W'(ent_valid[i]);
    end
  end

  // Fault table update: clear-all, retype an identical entry, or allocate
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
    end else if (inj_accept) begin
      if (inj_type == TYPE_CLR) begin
        ent_valid <= '0;
      end else if (match_hit) begin
        for (int i = 0; i < NUM_INJ; i++) begin
          if (match_sel[i]) ent_type[i] <= inj_type;
        end
      end else begin
        for (int i = 0; i < NUM_INJ; i++) begin
          if (alloc_sel[i]) begin
            ent_valid[i] <= 1'b1;
            ent_row[i]   <= inj_row;
            ent_col[i]   <= inj_col;
            ent_bit[i]   <= inj_bit;
            ent_type[i]  <= inj_type;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_faulty_mem_array.sv
// Bench for faulty_mem_array: directed scenarios followed by random traffic,
// all compared against a behavioural model of memory, spares and fault table.
module tb_faulty_mem_array;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst, wr_en, inj_valid, rep_row_en, rep_col_en;
  logic [3:0] row_addr, col_addr, inj_row, inj_col, rep_row, rep_col;
  logic [7:0] data_in, data_out;
  logic [2:0] inj_bit, inj_count;
  logic [1:0] inj_type;
  logic       mem_ready, inj_ready;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc;

  // model state
  bit [7:0] m_main [256];
  bit [7:0] m_srow [16];
  bit [7:0] m_scol [16];
  bit       m_ready;
  int       m_sweep;
  bit       m_v [NI];
  bit [3:0] m_r [NI];
  bit [3:0] m_c [NI];
  bit [2:0] m_b [NI];
  bit [1:0] m_t [NI];

  always #5 clk = ~clk;

  faulty_mem_array dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .row_addr(row_addr), .col_addr(col_addr),
    .data_in(data_in), .data_out(data_out), .mem_ready(mem_ready),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_row(inj_row), .inj_col(inj_col),
    .inj_bit(inj_bit), .inj_type(inj_type), .inj_count(inj_count),
    .rep_row_en(rep_row_en), .rep_row(rep_row), .rep_col_en(rep_col_en), .rep_col(rep_col)
  );

  function automatic bit m_is_row();
    return rep_row_en && row_addr == rep_row;
  endfunction

  function automatic bit m_is_col();
    return !m_is_row() && rep_col_en && col_addr == rep_col;
  endfunction

  function automatic bit m_hits(int i, bit [3:0] r, bit [3:0] c);
    return m_v[i] && m_r[i] == r && m_c[i] == c;
  endfunction

  function automatic logic [7:0] m_read();
    bit [7:0] v;
    if (!m_ready) return 8'h00;
    if (m_is_row()) return m_srow[col_addr];
    if (m_is_col()) return m_scol[row_addr];
    v = m_main[{row_addr, col_addr}];
    for (int i = 0; i < NI; i++) begin
      if (m_hits(i, row_addr, col_addr)) begin
        if (m_t[i] == 2'b01) v[m_b[i]] = 1'b0;
        if (m_t[i] == 2'b10) v[m_b[i]] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic int m_match();
    for (int i = 0; i < NI; i++)
      if (m_hits(i, inj_row, inj_col) && m_b[i] == inj_bit) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < NI; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  function automatic logic m_inj_ready();
    return inj_type == 2'b00 || m_free() >= 0 || m_match() >= 0;
  endfunction

  function automatic logic [2:0] m_count();
    int n = 0;
    for (int i = 0; i < NI; i++) n += int'(m_v[i]);
    return 3'(n);
  endfunction

  // apply one rising edge to the model using the inputs currently driven
  task automatic m_edge();
    bit [7:0] old_w, new_w;
    int k;
    if (rst) begin
      m_ready = 0;
      m_sweep = 0;
      for (int i = 0; i < NI; i++) m_v[i] = 0;
      return;
    end
    if (!m_ready) begin
      m_sweep++;
      if (m_sweep == 256) begin
        m_ready = 1;
        for (int i = 0; i < 256; i++) m_main[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin
          m_srow[i] = 8'h00;
          m_scol[i] = 8'h00;
        end
      end
    end else if (wr_en) begin
      if (m_is_row()) m_srow[col_addr] = data_in;
      else if (m_is_col()) m_scol[row_addr] = data_in;
      else begin
        old_w = m_main[{row_addr, col_addr}];
        new_w = data_in;
        for (int i = 0; i < NI; i++)
          if (m_hits(i, row_addr, col_addr) && m_t[i] == 2'b11 &&
              !old_w[m_b[i]] && data_in[m_b[i]])
            new_w[m_b[i]] = 1'b0;
        m_main[{row_addr, col_addr}] = new_w;
      end
    end
    if (inj_valid && m_inj_ready()) begin
      if (inj_type == 2'b00) begin
        for (int i = 0; i < NI; i++) m_v[i] = 0;
      end else if (m_match() >= 0) begin
        m_t[m_match()] = inj_type;
      end else begin
        k = m_free();
        m_v[k] = 1; m_r[k] = inj_row; m_c[k] = inj_col; m_b[k] = inj_bit; m_t[k] = inj_type;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // check all outputs against the model, then advance one clock
  task automatic step();
    #1;
    check("data_out", 32'(data_out), 32'(m_read()));
    check("inj_ready", 32'(inj_ready), 32'(m_inj_ready()));
    check("inj_count", 32'(inj_count), 32'(m_count()));
    check("mem_ready", 32'(mem_ready), 32'(m_ready));
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic wr(bit [3:0] r, bit [3:0] c, bit [7:0] d);
    row_addr = r; col_addr = c; data_in = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_check(string tag, bit [3:0] r, bit [3:0] c, bit [7:0] exp);
    row_addr = r; col_addr = c; wr_en = 1'b0;
    #1 check(tag, 32'(data_out), 32'(exp));
    step();
  endtask

  task automatic inject(bit [1:0] t, bit [3:0] r, bit [3:0] c, bit [2:0] b);
    inj_type = t; inj_row = r; inj_col = c; inj_bit = b; inj_valid = 1'b1;
    step();
    inj_valid = 1'b0;
  endtask

  task automatic wait_ready(string tag, bit inject_first);
    cyc = 0;
    while (!mem_ready && cyc < 400) begin
      inj_valid = inject_first && cyc == 0;
      step();
      cyc++;
    end
    inj_valid = 1'b0;
    check(tag, 32'(cyc), 32'd256);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; inj_valid = 1'b0; rep_row_en = 1'b0; rep_col_en = 1'b0;
    row_addr = '0; col_addr = '0; data_in = '0; inj_row = '0; inj_col = '0;
    inj_bit = '0; inj_type = '0; rep_row = '0; rep_col = '0;
    m_ready = 0; m_sweep = 0;
    for (int i = 0; i < NI; i++) m_v[i] = 0;

    // first edge in reset brings the DUT out of its unknown power-up state
    @(posedge clk);
    m_edge();
    #1;
    check("reset_mem_ready", 32'(mem_ready), 32'd0);
    check("reset_inj_count", 32'(inj_count), 32'd0);
    step();
    rst = 1'b0;

    wait_ready("init_latency", 1'b0);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) rd_check("init_zero", 4'(r), 4'(c), 8'h00);

    // stuck-at-1 on (3,5) bit 2
    inject(2'b10, 4'd3, 4'd5, 3'd2);
    wr(4'd3, 4'd5, 8'h00);
    rd_check("sa1_cell", 4'd3, 4'd5, 8'h04);
    rd_check("sa1_neighbour", 4'd3, 4'd4, 8'h00);

    // transition fault on (0,0) bit 7
    inject(2'b11, 4'd0, 4'd0, 3'd7);
    wr(4'd0, 4'd0, 8'hFF);
    rd_check("tf_first", 4'd0, 4'd0, 8'h7F);
    wr(4'd0, 4'd0, 8'h00);
    rd_check("tf_fall", 4'd0, 4'd0, 8'h00);
    wr(4'd0, 4'd0, 8'hFF);
    rd_check("tf_rise", 4'd0, 4'd0, 8'h7F);

    // fill the table
    inject(2'b01, 4'd7, 4'd7, 3'd0);
    inject(2'b10, 4'd1, 4'd1, 3'd1);
    #1 check("table_full_count", 32'(inj_count), 32'd4);
    inj_type = 2'b01; inj_row = 4'd9; inj_col = 4'd9; inj_bit = 3'd0;
    #1 check("full_new_cell", 32'(inj_ready), 32'd0);
    inj_type = 2'b10; inj_row = 4'd3; inj_col = 4'd5; inj_bit = 3'd2;
    #1 check("full_duplicate", 32'(inj_ready), 32'd1);
    inj_type = 2'b00; inj_row = 4'd9; inj_col = 4'd9;
    #1 check("full_clear_ok", 32'(inj_ready), 32'd1);

    // stuck-at-0 on (7,7) bit 0, then spare-row remap hides it
    wr(4'd7, 4'd7, 8'hFF);
    rd_check("sa0_cell", 4'd7, 4'd7, 8'hFE);
    rep_row_en = 1'b1; rep_row = 4'd7;
    wr(4'd7, 4'd7, 8'hFF);
    rd_check("spare_row_read", 4'd7, 4'd7, 8'hFF);
    rep_row_en = 1'b0;
    rd_check("main_after_unmap", 4'd7, 4'd7, 8'hFE);

    // retype an existing entry, then clear all
    inject(2'b01, 4'd3, 4'd5, 3'd2);
    rd_check("retyped_sa0", 4'd3, 4'd5, 8'h00);
    #1 check("retype_count", 32'(inj_count), 32'd4);
    inject(2'b00, 4'd0, 4'd0, 3'd0);
    #1 check("clear_count", 32'(inj_count), 32'd0);
    rd_check("after_clear", 4'd7, 4'd7, 8'hFF);

    // spare column
    rep_col_en = 1'b1; rep_col = 4'd3;
    wr(4'd5, 4'd3, 8'hAA);
    rd_check("spare_col_read", 4'd5, 4'd3, 8'hAA);
    rep_col_en = 1'b0;
    rd_check("spare_col_unmap", 4'd5, 4'd3, 8'h00);

    // reset at sweep address 100, with an injection accepted during INIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    #1 check("midsweep_ready_low", 32'(mem_ready), 32'd0);
    rst = 1'b0;
    inj_type = 2'b10; inj_row = 4'd2; inj_col = 4'd2; inj_bit = 3'd3;
    wait_ready("restart_latency", 1'b1);
    #1 check("init_inject_count", 32'(inj_count), 32'd1);
    rd_check("init_inject_read", 4'd2, 4'd2, 8'h08);

    // random traffic
    for (int n = 0; n < 2500; n++) begin
      rst        = ($urandom_range(0, 799) == 0);
      wr_en      = $urandom_range(0, 1);
      row_addr   = 4'($urandom_range(0, 5));
      col_addr   = 4'($urandom_range(0, 5));
      data_in    = 8'($urandom);
      inj_valid  = ($urandom_range(0, 5) == 0);
      inj_type   = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      inj_row    = 4'($urandom_range(0, 3));
      inj_col    = 4'($urandom_range(0, 3));
      inj_bit    = 3'($urandom);
      rep_row_en = ($urandom_range(0, 3) == 0);
      rep_row    = 4'($urandom_range(0, 5));
      rep_col_en = ($urandom_range(0, 3) == 0);
      rep_col    = 4'($urandom_range(0, 5));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/faulty_mem_array.md
FAULTY_MEM_ARRAY -- requirements
Module: faulty_mem_array

Interface
REQ-001 Parameter ROW_ADDR_WIDTH, default 4, row address bits.
REQ-002 Parameter COL_ADDR_WIDTH, default 4, column address bits.
REQ-003 Parameter DATA_WIDTH, default 8, word width.
REQ-004 Parameter NUM_INJ, default 4, number of fault-injection table entries.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  write strobe from the MBIST controller.
REQ-008 row_addr  in  ROW_ADDR_WIDTH  access row.
REQ-009 col_addr  in  COL_ADDR_WIDTH  access column.
REQ-010 data_in  in  DATA_WIDTH  write data.
REQ-011 data_out  out  DATA_WIDTH  read data for current address.
REQ-012 mem_ready  out  1  high once initialization sweep is complete.
REQ-013 inj_valid  in  1  injection request.
REQ-014 inj_ready  out  1  injection request can be accepted.
REQ-015 inj_row / inj_col / inj_bit  in  ROW_ADDR_WIDTH / COL_ADDR_WIDTH / $clog2(DATA_WIDTH)  faulty cell and bit.
REQ-016 inj_type  in  2  00 clear-all, 01 stuck-at-0, 10 stuck-at-1, 11 transition fault (0->1 blocked).
REQ-017 inj_count  out  $clog2(NUM_INJ+1)  number of occupied table entries.
REQ-018 rep_row_en / rep_row  in  1 / ROW_ADDR_WIDTH  spare-row remap enable and target row.
REQ-019 rep_col_en / rep_col  in  1 / COL_ADDR_WIDTH  spare-column remap enable and target column.

Function
REQ-020 FSM states: INIT, READY; INIT entered on reset, READY entered after the sweep, READY held until reset.
REQ-021 INIT: sweep counter writes 0 to every main cell, spare-row word and spare-column word, one address per cycle, 2^(ROW_ADDR_WIDTH+COL_ADDR_WIDTH) cycles total (256 at defaults); spare words cleared alongside the main-array sweep.
REQ-022 mem_ready rises in the cycle after the last sweep write; wr_en ignored and data_out = 0 while in INIT.
REQ-023 Read is asynchronous: data_out reflects stored content of (row_addr, col_addr) in the same cycle, with fault overlay applied.
REQ-024 Read-before-write: when wr_en = 1, data_out shows the old content; the new word is committed at the rising edge.
REQ-025 Remap priority: rep_row_en and row_addr == rep_row selects spare-row word [col_addr]; else rep_col_en and col_addr == rep_col selects spare-column word [row_addr]; else main array.
REQ-026 Spare storage is fault-free; injected faults apply only to main-array accesses.
REQ-027 Stuck-at-0/1: data_out bit inj_bit of the matching cell forced to 0/1; stored bit still written normally.
REQ-028 Transition fault: on write to the matching cell, if stored bit is 0 and data_in bit is 1, stored bit stays 0; 1->0 writes and reads are unaffected.
REQ-029 Multiple entries on the same cell with different bits all apply; stuck-at overlay is applied after storage read.
REQ-030 Injection handshake: entry accepted on a rising edge where inj_valid and inj_ready are both 1; takes effect from the next cycle.
REQ-031 inj_ready = 1 if inj_type == 00, or a free entry exists, or an entry with identical (row, col, bit) exists; else 0.
REQ-032 Identical (row, col, bit) overwrites that entry's type; inj_count unchanged.
REQ-033 inj_type 00 invalidates all entries; inj_count becomes 0 next cycle.
REQ-034 New entries fill the lowest-index free slot; inj_count increments by 1 and saturates at NUM_INJ.
REQ-035 Injection is accepted in both INIT and READY; the sweep does not clear the table.
REQ-036 Remap inputs are sampled combinationally each access; changing them mid-run redirects the next access with no state loss.

Reset
REQ-037 Reset in any state: FSM to INIT, sweep counter 0, mem_ready 0, all injection entries invalid, inj_count 0; reset mid-sweep restarts the sweep from address 0.
REQ-038 Array contents need no per-cell reset; contents are defined only after the INIT sweep completes.

Verification
REQ-039 Reset, count cycles -> mem_ready rises after exactly 256 cycles; every main-array read returns 0x00.
REQ-040 Inject SA1 at (3,5) bit 2, write 0x00 to (3,5) -> read returns 0x04; other cells read 0x00.
REQ-041 Inject transition fault at (0,0) bit 7, write 0xFF -> read 0x7F; write 0x00 then 0xFF -> read 0x7F.
REQ-042 Fill 4 distinct entries -> inj_ready 0 for a new 5th cell, 1 for a duplicate cell/bit, 1 for type 00; apply type 00 -> inj_count 0.
REQ-043 SA0 at (7,7) bit 0, write 0xFF -> read 0xFE; set rep_row_en, rep_row = 7, write 0xFF to (7,7) -> read 0xFF.
REQ-044 Assert rst at sweep address 100 -> mem_ready stays 0 and rises exactly 256 cycles after rst is released.
